// File: rtl/conv3_dw.sv
// conv3_dw: depthwise 3x3 convolution + ReLU6 over a raster pixel stream, CH channels in parallel.
// Latency: input reg -> window update -> output reg; ready rises on the 3rd edge counting the edge that samples the beat.
// Backpressure: none; one beat per cycle, gaps in valid simply stall counters and window.
// Optional: define CONV3_DW_SATCNT_EN to add sat_cnt (running count of channels clamped high).
module conv3_dw #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int CH    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid,
  input  logic [CH*8-1:0]  input_act,
  input  logic [CH*18-1:0] weights,
  input  logic [CH*4-1:0]  bias,
  output logic [CH*8-1:0]  output_act,
  output logic             ready
`ifdef CONV3_DW_SATCNT_EN
  ,
  output logic [15:0]      sat_cnt
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CH*8-1:0]    in_ff;
  logic               v_ff;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [CH*8-1:0]    lb0 [IMG_W];
  logic [CH*8-1:0]    lb1 [IMG_W];
  // win[3*ky+kx]: ky=0 oldest row, kx=0 oldest column
  logic [CH*8-1:0]    win [9];
  logic               win_rdy;
  logic signed [13:0] acc;
  logic [CH-1:0]      hi;
  logic [CH*8-1:0]    relu;

  // Stage 1: register the incoming beat unconditionally
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_ff <= '0;
      v_ff  <= 1'b0;
    end else begin
      in_ff <= input_act;
      v_ff  <= valid;
    end
  end

  // Line buffers: LB0 holds the previous row, LB1 the row before it; contents need no reset
  always_ff @(posedge clk) begin
    if (v_ff) begin
      lb0[col] <= in_ff;
      lb1[col] <= lb0[col];
    end
  end

  // Stage 2: slide the window, advance raster counters, flag windows that are fully in-frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col     <= '0;
      row     <= '0;
      win_rdy <= 1'b0;
      for (int t = 0; t < 9; t++) win[t] <= '0;
    end else begin
      win_rdy <= v_ff && (row >= RW'(2)) && (col >= CW'(2));
      if (v_ff) begin
        for (int ky = 0; ky < 3; ky++) begin
          win[3*ky]   <= win[3*ky+1];
          win[3*ky+1] <= win[3*ky+2];
        end
        win[2] <= lb1[col];
        win[5] <= lb0[col];
        win[8] <= in_ff;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Per-channel 9-tap MAC at 14-bit signed width, then ReLU6 clamp
  always_comb begin
    acc  = '0;
    hi   = '0;
    relu = '0;
    for (int k = 0; k < CH; k++) begin
      acc = 14'(signed'(bias[4*k +: 4]));
      for (int t = 0; t < 9; t++) begin
        acc = acc + 14'(signed'(win[t][8*k +: 8])) * 14'(signed'(weights[2*(9*k+t) +: 2]));
      end
      hi[k] = (acc > 14'sd6);
      relu[8*k +: 8] = acc[13] ? 8'd0 : (hi[k] ? 8'd6 : acc[7:0]);
    end
  end

  // Stage 3: load the output only for in-frame windows; otherwise hold the last value
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      output_act <= '0;
      ready      <= 1'b0;
    end else begin
      ready <= win_rdy;
      if (win_rdy) output_act <= relu;
    end
  end

`ifdef CONV3_DW_SATCNT_EN
  logic [16:0] sat_sum;

  // Add the number of high-clamped channels of the current output to the running count
  always_comb begin
    sat_sum = {1'b0, sat_cnt};
    for (int k = 0; k < CH; k++) sat_sum = sat_sum + 17'(hi[k]);
  end

  // Saturating counter, bumped alongside each output load
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_cnt <= '0;
    end else if (win_rdy) begin
      sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_conv3_dw.sv
// tb_conv3_dw: self-checking bench for conv3_dw on a 4x4 frame, 16 channels.
// Expected outputs come from a frame-array reference model plus hand-computed constant tables.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_conv3_dw;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CH = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             valid = 1'b0;
  logic [CH*8-1:0]  input_act = '0;
  logic [CH*18-1:0] weights = '0;
  logic [CH*4-1:0]  bias = '0;
  logic [CH*8-1:0]  output_act;
  logic             ready;
`ifdef CONV3_DW_SATCNT_EN
  logic [15:0]      sat_cnt;
`endif

  int total = 0;
  int bad = 0;

  conv3_dw #(.IMG_W(W), .IMG_H(H), .CH(CH)) dut (
    .clk(clk),
    .rstn(rstn),
    .valid(valid),
    .input_act(input_act),
    .weights(weights),
    .bias(bias),
    .output_act(output_act),
    .ready(ready)
`ifdef CONV3_DW_SATCNT_EN
    ,
    .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int              pix [H][W][CH];
  int              mi = 0;
  logic [CH*8-1:0] exp_q [$];
  int              hi_q [$];
  logic [CH*8-1:0] obs_q [$];
  int              n_rdy = 0;
  int              exp_sat = 0;
  logic [CH*8-1:0] last_out = '0;

  function automatic int wt(input int k, input int t);
    int w;
    w = int'(weights[2*(9*k+t) +: 2]);
    if (w > 1) w -= 4;
    return w;
  endfunction

  function automatic int bs(input int k);
    int b;
    b = int'(bias[4*k +: 4]);
    if (b > 7) b -= 16;
    return b;
  endfunction

  task automatic model_beat(input logic [CH*8-1:0] act);
    int r, c, a, nh, v;
    logic [CH*8-1:0] e;
    r = mi / W;
    c = mi % W;
    for (int k = 0; k < CH; k++) begin
      v = int'(act[8*k +: 8]);
      if (v > 127) v -= 256;
      pix[r][c][k] = v;
    end
    if (r >= 2 && c >= 2) begin
      e = '0;
      nh = 0;
      for (int k = 0; k < CH; k++) begin
        a = bs(k);
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            a += pix[r-2+ky][c-2+kx][k] * wt(k, 3*ky+kx);
        if (a < 0) e[8*k +: 8] = 8'd0;
        else if (a > 6) begin e[8*k +: 8] = 8'd6; nh++; end
        else e[8*k +: 8] = 8'(a);
      end
      exp_q.push_back(e);
      hi_q.push_back(nh);
    end
    mi = (mi + 1) % (W*H);
  endtask

  task automatic check(input string name, input logic [CH*8-1:0] got, input logic [CH*8-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // ---------------- output monitor ----------------
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (ready) begin
        n_rdy++;
        obs_q.push_back(output_act);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready got=1 want=0 out=%h", output_act);
        end else begin
          check("model_out", output_act, exp_q.pop_front());
`ifdef CONV3_DW_SATCNT_EN
          exp_sat += hi_q.pop_front();
          if (exp_sat > 65535) exp_sat = 65535;
          check_int("sat_cnt", int'(sat_cnt), exp_sat);
`else
          void'(hi_q.pop_front());
`endif
        end
        last_out = output_act;
      end else begin
        check("hold", output_act, last_out);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic beat(input logic [CH*8-1:0] act);
    @(negedge clk);
    valid = 1'b1;
    input_act = act;
    model_beat(act);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
    end
  endtask

  function automatic logic [CH*8-1:0] gen(input int mode, input logic [7:0] cval, input int r, input int c);
    logic [CH*8-1:0] g;
    g = '0;
    for (int k = 0; k < CH; k++) begin
      case (mode)
        0:       g[8*k +: 8] = cval;
        1:       g[8*k +: 8] = 8'((r*W + c) % 7);
        default: g[8*k +: 8] = 8'($urandom);
      endcase
    end
    return g;
  endfunction

  // gap: 0 continuous, 1 toggle every cycle, 2 random gaps
  task automatic run_frame(input int mode, input logic [7:0] cval, input int gap);
    for (int i = 0; i < W*H; i++) begin
      beat(gen(mode, cval, i / W, i % W));
      if (gap == 1) idle(1);
      else if (gap == 2 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(5);
  endtask

  task automatic set_uniform(input logic [1:0] wc, input logic [1:0] wo, input logic [3:0] b);
    for (int k = 0; k < CH; k++) begin
      for (int t = 0; t < 9; t++) weights[2*(9*k+t) +: 2] = (t == 4) ? wc : wo;
      bias[4*k +: 4] = b;
    end
  endtask

  task automatic set_random;
    for (int i = 0; i < CH*18; i++) weights[i] = 1'($urandom);
    for (int i = 0; i < CH*4; i++) bias[i] = 1'($urandom);
  endtask

  // ---------------- constant-frame vectors ----------------
  typedef struct {
    logic [7:0] px;
    logic [1:0] wc;
    logic [1:0] wo;
    logic [3:0] b;
    logic [7:0] exp_v;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int n0;
    logic [CH*8-1:0] e2;
    int exp3 [4];

    tbl[0]  = '{8'h01, 2'b01, 2'b01, 4'h0, 8'd6};  // 9 clamped
    tbl[1]  = '{8'hFD, 2'b10, 2'b00, 4'h0, 8'd6};  // -3*-2 = 6
    tbl[2]  = '{8'hFD, 2'b01, 2'b00, 4'h0, 8'd0};  // -3 clamped low
    tbl[3]  = '{8'h02, 2'b01, 2'b00, 4'h1, 8'd3};
    tbl[4]  = '{8'h01, 2'b11, 2'b00, 4'h5, 8'd4};
    tbl[5]  = '{8'h00, 2'b00, 2'b00, 4'h8, 8'd0};  // bias -8
    tbl[6]  = '{8'hFF, 2'b11, 2'b11, 4'hC, 8'd5};  // 9 - 4
    tbl[7]  = '{8'h03, 2'b01, 2'b00, 4'h3, 8'd6};  // exactly 6
    tbl[8]  = '{8'h01, 2'b01, 2'b00, 4'h6, 8'd6};  // 7 clamped
    tbl[9]  = '{8'h80, 2'b10, 2'b10, 4'h8, 8'd6};  // 2296, max magnitude
    tbl[10] = '{8'h80, 2'b01, 2'b01, 4'h8, 8'd0};  // -1160
    tbl[11] = '{8'h02, 2'b01, 2'b11, 4'h7, 8'd0};  // -7
    tbl[12] = '{8'hFF, 2'b01, 2'b00, 4'h1, 8'd0};  // exactly 0

    // reset state
    repeat (3) @(negedge clk);
    check("reset_out", output_act, '0);
    check_int("reset_rdy", int'(ready), 0);
`ifdef CONV3_DW_SATCNT_EN
    check_int("reset_sat", int'(sat_cnt), 0);
`endif
    rstn = 1'b1;

    // first-output latency: ready rises on the 3rd edge counting the one that samples beat 11
    set_uniform(2'b01, 2'b01, 4'h0);
    n0 = n_rdy;
    for (int i = 0; i < 11; i++) beat(gen(0, 8'h01, 0, 0));
    @(negedge clk);
    valid = 1'b0;
    check_int("lat_edge1", int'(ready), 0);
    @(negedge clk);
    check_int("lat_edge2", int'(ready), 0);
    @(negedge clk);
    check_int("lat_edge3", int'(ready), 1);
    for (int i = 11; i < W*H; i++) beat(gen(0, 8'h01, 0, 0));
    idle(5);
    check_int("lat_frame_cnt", n_rdy - n0, 4);

    // constant frames from the table
    for (int i = 0; i < 13; i++) begin
      set_uniform(tbl[i].wc, tbl[i].wo, tbl[i].b);
      obs_q.delete();
      n0 = n_rdy;
      run_frame(0, tbl[i].px, 0);
      check_int($sformatf("tbl%0d_cnt", i), n_rdy - n0, 4);
      foreach (obs_q[j]) check($sformatf("tbl%0d_out%0d", i, j), obs_q[j], {CH{tbl[i].exp_v}});
    end

    // per-channel bias k-8 on a zero frame
    set_uniform(2'b01, 2'b01, 4'h0);
    for (int k = 0; k < CH; k++) bias[4*k +: 4] = 4'(k - 8);
    e2 = '0;
    for (int k = 9; k < 15; k++) e2[8*k +: 8] = 8'(k - 8);
    e2[8*15 +: 8] = 8'd6;
    obs_q.delete();
    run_frame(0, 8'h00, 0);
    check_int("bias_cnt", obs_q.size(), 4);
    foreach (obs_q[j]) check($sformatf("bias_out%0d", j), obs_q[j], e2);

    // centre tap only: output equals the centre pixel
    set_uniform(2'b01, 2'b00, 4'h0);
    exp3 = '{5, 6, 2, 3};
    obs_q.delete();
    run_frame(1, 8'h00, 0);
    check_int("ctr_cnt", obs_q.size(), 4);
    foreach (obs_q[j]) check($sformatf("ctr_out%0d", j), obs_q[j], {CH{8'(exp3[j])}});

    // valid toggling over two frames
    set_random();
    n0 = n_rdy;
    run_frame(2, 8'h00, 1);
    run_frame(2, 8'h00, 1);
    check_int("toggle_cnt", n_rdy - n0, 8);

    // random frames with random gaps and coefficients
    for (int f = 0; f < 8; f++) begin
      set_random();
      n0 = n_rdy;
      run_frame(2, 8'h00, (f % 2 == 0) ? 0 : 2);
      check_int($sformatf("rand%0d_cnt", f), n_rdy - n0, 4);
    end

    // reset mid-frame after 7 beats
    set_uniform(2'b01, 2'b01, 4'h0);
    for (int i = 0; i < 7; i++) beat(gen(0, 8'h01, 0, 0));
    @(negedge clk);
    valid = 1'b0;
    rstn = 1'b0;
    mi = 0;
    exp_q.delete();
    hi_q.delete();
    exp_sat = 0;
    last_out = '0;
    #1;
    check("midrst_out", output_act, '0);
    check_int("midrst_rdy", int'(ready), 0);
`ifdef CONV3_DW_SATCNT_EN
    check_int("midrst_sat", int'(sat_cnt), 0);
`endif
    repeat (2) @(negedge clk);
    check("midrst_out_hold", output_act, '0);
    rstn = 1'b1;
    obs_q.delete();
    n0 = n_rdy;
    run_frame(0, 8'h01, 0);
    check_int("midrst_cnt", n_rdy - n0, 4);
    foreach (obs_q[j]) check($sformatf("midrst_out%0d", j), obs_q[j], {CH{8'd6}});

    check_int("model_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
